// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default
// vector table layout.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int ID_W = 3;

  localparam logic [9:0] DEF_VEC_BASE   = 10'h3F0;
  localparam int         DEF_VEC_STRIDE = 4;

endpackage

// File: rtl/int_sync_edge.sv
// One interrupt line: two-flop synchroniser, a third flop holding the
// previous synchronised value, and a single-cycle rising-edge pulse.
module int_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Shift the asynchronous line through the synchroniser and edge-detect flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed
// lowest-index-first priority and the request/ack/service/return handshake
// with the CPU control unit. Every output comes straight from a flop.
module int_ctrl
  import int_pkg::*;
#(
  parameter int                N_IRQ      = 4,
  parameter int                VEC_W      = 10,
  parameter logic [VEC_W-1:0]  VEC_BASE   = VEC_W'(DEF_VEC_BASE),
  parameter int                VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_in,
  input  logic              gie,
  input  logic              int_ack,
  input  logic              reti,
  output logic              int_req,
  output logic [VEC_W-1:0]  int_vec,
  output logic [ID_W-1:0]   int_id,
  output logic              in_service,
  output logic [N_IRQ-1:0]  pending,
  output logic [N_IRQ-1:0]  mask
);

  state_t            state;
  logic [N_IRQ-1:0]  rise;
  logic [N_IRQ-1:0]  eligible;
  logic [N_IRQ-1:0]  ack_clr;
  logic [ID_W-1:0]   winner;
  logic              any_eligible;
  logic [VEC_W-1:0]  winner_vec;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    int_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq[g]),
      .rise  (rise[g])
    );
  end

  assign eligible     = pending & mask;
  assign any_eligible = |eligible;

  // Priority encoder: scanning downwards lets the lowest eligible index win
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // Vector table entry for the winner; wraps modulo 2**VEC_W by width
  assign winner_vec = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(winner);

  // One-hot clear of the latched source when the CPU takes the request
  always_comb begin
    ack_clr = '0;
    if (state == REQ && int_ack) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (int_id == ID_W'(i)) ack_clr[i] = 1'b1;
      end
    end
  end

  // Pending bits: a fresh edge always survives a coincident acknowledge clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~ack_clr) | rise;
  end

  // Software mask register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mask <= '0;
    else if (mask_we) mask <= mask_in;
  end

  // Handshake FSM; the request is frozen once issued and nothing nests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vec    <= '0;
      int_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gie && any_eligible) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_id  <= winner;
            int_vec <= winner_vec;
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERVICE;
            int_req    <= 1'b0;
            int_vec    <= '0;
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (reti) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          int_vec    <= '0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed walk through the handshake scenarios followed
// by a randomized stretch, all checked every cycle against a behavioural
// model built from sampled-input history rather than flop-level structure.
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_in;
  logic        gie;
  logic        int_ack;
  logic        reti;
  logic        int_req;
  logic [9:0]  int_vec;
  logic [2:0]  int_id;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 = idle, 1 = requesting, 2 = handler running
  int        m_phase;
  int        m_id;
  bit [3:0]  m_pend;
  bit [3:0]  m_mask;
  bit [3:0]  hist [3];

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .gie        (gie),
    .int_ack    (int_ack),
    .reti       (reti),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_id    = 0;
    m_pend  = '0;
    m_mask  = '0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // A line counts as newly raised when it was sampled high two edges ago
  // and low three edges ago; pending then rises on the current edge.
  task automatic model_step();
    bit [3:0] raised;
    bit [3:0] elig;
    bit [3:0] clr;
    int       nxt;
    bit       found;
    raised = hist[1] & ~hist[2];
    elig   = m_pend & m_mask;
    clr    = '0;
    nxt    = m_phase;
    found  = 1'b0;
    if (m_phase == 0) begin
      if (gie && elig != 0) begin
        for (int i = 0; i < 4; i++) begin
          if (elig[i] && !found) begin
            m_id  = i;
            found = 1'b1;
          end
        end
        nxt = 1;
      end
    end else if (m_phase == 1) begin
      if (int_ack) begin
        clr[m_id] = 1'b1;
        nxt = 2;
      end
    end else begin
      if (reti) nxt = 0;
    end
    m_phase = nxt;
    m_pend  = (m_pend & ~clr) | raised;
    if (mask_we) m_mask = mask_in;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq;
  endtask

  task automatic model_check();
    int exp_vec;
    chk("int_req", 32'(int_req), 32'(m_phase == 1));
    chk("in_service", 32'(in_service), 32'(m_phase == 2));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("mask", 32'(mask), 32'(m_mask));
    if (m_phase == 1) begin
      exp_vec = (1008 + m_id * 4) % 1024;
      chk("int_vec", 32'(int_vec), 32'(exp_vec));
    end
    if (m_phase != 0) chk("int_id", 32'(int_id), 32'(m_id));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write_mask(input logic [3:0] value);
    mask_we = 1'b1;
    mask_in = value;
    cycle();
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] lines);
    irq = lines;
    cycle();
    irq = 4'b0000;
  endtask

  task automatic ack_then_return();
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    cycle();
    reti = 1'b1;
    cycle();
    reti = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    irq     = '0;
    mask_we = 1'b0;
    mask_in = '0;
    gie     = 1'b0;
    int_ack = 1'b0;
    reti    = 1'b0;
    model_reset();

    #12;
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_int_vec", 32'(int_vec), 32'd0);
    chk("rst_int_id", 32'(int_id), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cycles(2);

    // Single source: request three edges after the sample, then full handshake
    write_mask(4'b1111);
    gie = 1'b1;
    pulse(4'b0100);
    cycles(2);
    chk("irq2_not_yet", 32'(int_req), 32'd0);
    cycle();
    chk("irq2_req", 32'(int_req), 32'd1);
    chk("irq2_vec", 32'(int_vec), 32'h3F8);
    chk("irq2_id", 32'(int_id), 32'd2);
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    chk("irq2_pend_clr", 32'(pending[2]), 32'd0);
    chk("irq2_in_svc", 32'(in_service), 32'd1);
    cycle();
    reti = 1'b1;
    cycle();
    reti = 1'b0;
    cycle();
    chk("irq2_idle", 32'(int_req), 32'd0);

    // Simultaneous edges on 3 and 1: lowest index first, then 3 after IDLE
    pulse(4'b1010);
    cycles(3);
    chk("dual_id_first", 32'(int_id), 32'd1);
    chk("dual_vec_first", 32'(int_vec), 32'h3F4);
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    cycle();
    reti = 1'b1;
    cycle();
    reti = 1'b0;
    chk("dual_idle_gap", 32'(int_req), 32'd0);
    cycle();
    chk("dual_id_second", 32'(int_id), 32'd3);
    chk("dual_vec_second", 32'(int_vec), 32'h3FC);
    ack_then_return();
    cycle();

    // Masked source stays pending until the mask opens
    write_mask(4'b1110);
    pulse(4'b0001);
    cycles(4);
    chk("masked_pend", 32'(pending[0]), 32'd1);
    chk("masked_noreq", 32'(int_req), 32'd0);
    write_mask(4'b1111);
    chk("unmask_same_cycle", 32'(int_req), 32'd0);
    cycle();
    chk("unmask_req", 32'(int_req), 32'd1);
    chk("unmask_vec", 32'(int_vec), 32'h3F0);
    ack_then_return();
    cycle();

    // Second edge on line 1 lands on the ack clear; line 0 waits out service
    pulse(4'b0010);
    cycle();
    pulse(4'b0010);
    cycle();
    chk("svc1_id", 32'(int_id), 32'd1);
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    chk("set_beats_clr", 32'(pending[1]), 32'd1);
    chk("svc1_in_svc", 32'(in_service), 32'd1);
    pulse(4'b0001);
    cycles(4);
    chk("no_nesting", 32'(int_req), 32'd0);
    chk("nest_pend0", 32'(pending[0]), 32'd1);
    reti = 1'b1;
    cycle();
    reti = 1'b0;
    chk("nest_idle_gap", 32'(int_req), 32'd0);
    cycle();
    chk("after_nest_id", 32'(int_id), 32'd0);
    ack_then_return();
    cycle();
    chk("redo1_id", 32'(int_id), 32'd1);
    ack_then_return();
    cycle();

    // Asynchronous reset while a request is outstanding
    pulse(4'b0100);
    cycles(3);
    chk("pre_rst_req", 32'(int_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(int_req), 32'd0);
    chk("async_rst_pend", 32'(pending), 32'd0);
    chk("async_rst_mask", 32'(mask), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Global enable low holds off an eligible source
    gie = 1'b0;
    write_mask(4'b1111);
    pulse(4'b0010);
    cycles(6);
    chk("gie_off_noreq", 32'(int_req), 32'd0);
    chk("gie_off_pend", 32'(pending[1]), 32'd1);
    gie = 1'b1;
    cycle();
    chk("gie_on_req", 32'(int_req), 32'd1);
    chk("gie_on_id", 32'(int_id), 32'd1);
    ack_then_return();
    cycle();

    // Randomized traffic, including stray ack/reti and mask/gie churn
    for (int n = 0; n < 600; n++) begin
      irq     = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      mask_we = ($urandom_range(0, 9) == 0);
      mask_in = 4'($urandom_range(0, 15));
      gie     = ($urandom_range(0, 7) != 0);
      int_ack = ($urandom_range(0, 2) == 0);
      reti    = ($urandom_range(0, 3) == 0);
      cycle();
    end
    irq     = '0;
    mask_we = 1'b0;
    int_ack = 1'b0;
    reti    = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt controller for the single-cycle CPU.
- Synchronises external interrupt lines, latches rising edges as pending, applies a software mask, and picks one source by fixed priority.
- Sequences the CPU handshake: request, acknowledge, in-service, return.
- Supplies the handler vector. On acknowledge, the CPU control unit pushes the PC on the subroutine stack and loads the vector.

Parameters:
- N_IRQ, 4, number of interrupt sources (1..8).
- VEC_W, 10, PC/vector width in bits.
- VEC_BASE, 10'h3F0, vector of source 0.
- VEC_STRIDE, 4, address distance between consecutive source vectors.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- irq  in  N_IRQ  external interrupt lines, asynchronous, rising-edge significant.
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  N_IRQ  new mask value (1 = enabled).
- gie  in  1  global interrupt enable from CPU.
- int_ack  in  1  CPU accepts the current request this cycle.
- reti  in  1  CPU executes return-from-interrupt this cycle.
- int_req  out  1  interrupt request to CPU control unit.
- int_vec  out  VEC_W  handler address, valid while int_req = 1.
- int_id  out  3  index of requested/in-service source.
- in_service  out  1  a handler is executing.
- pending  out  N_IRQ  pending bits, for software read.
- mask  out  N_IRQ  current mask register.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Sync flops, pending, mask all 0.
  - State IDLE.
  - int_req = 0, int_vec = 0, int_id = 0, in_service = 0.
- Synchroniser: two flops per line, plus a third flop for edge detect. edge[i] = s2[i] & ~s3[i].
- Pending:
  - pending[i] is set on edge[i] regardless of mask.
  - pending[i] is cleared when int_ack is taken for source i.
  - If set and clear coincide, set wins (the new edge is not lost).
- Mask register: loaded from mask_in on clk when mask_we = 1. No other effect.
- Selection: eligible = pending & mask. Winner = lowest index set. Combinational, one priority encoder.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if gie = 1 and eligible != 0, latch the winner into int_id and go to REQ.
  - REQ:
    - int_req = 1.
    - int_vec = VEC_BASE + int_id*VEC_STRIDE, truncated to VEC_W (wrap-around).
    - The latched id is held. Later higher-priority edges, mask changes or gie drop do not withdraw or change the request.
    - On int_ack = 1: clear pending[int_id], drop int_req next cycle, go to SERVICE.
  - SERVICE:
    - in_service = 1, int_id holds the serviced source.
    - No nesting: new eligible sources stay pending.
    - On reti = 1 go to IDLE.
- Ignored inputs: int_ack outside REQ is ignored. reti outside SERVICE is ignored.
- Re-arbitration: the earliest next request is one cycle after the return to IDLE. IDLE is always visited for at least one cycle.
- Latency: irq high at sampling edge k sets s1. Timeline:
  - k+1: s2 set.
  - k+2: pending set.
  - k+3: REQ entered; int_req is high after edge k+3.
  - Minimum irq pulse: one full clock period high.
- All outputs are registered or decoded from registered state. No combinational path from irq to int_req.
- Reset mid-operation: immediate return to IDLE. Pending requests and mask are lost.

Decomposition:
- Shared package int_pkg:
  - FSM state encoding: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2.
  - Default VEC_BASE and VEC_STRIDE.
- One sub-module, int_sync_edge: per-line 3-flop synchroniser plus rising-edge pulse. Instantiated N_IRQ times via generate.
- The priority encoder stays inline.

Test Plan:
- Reset release with irq = 0: all outputs 0, state IDLE.
- mask = 4'b1111, gie = 1, pulse irq[2] at edge k: int_req = 1 after edge k+3, int_vec = 10'h3F8, int_id = 2. int_ack one cycle later: pending[2] = 0, in_service = 1. reti: back to IDLE, int_req stays 0.
- irq[3] and irq[1] rise in the same cycle: id 1 served first (vector 10'h3F4). After reti plus one IDLE cycle, id 3 is requested (vector 10'h3FC).
- mask = 4'b1110, pulse irq[0]: pending[0] = 1, no int_req. Write mask = 4'b1111: int_req with vector 10'h3F0 one cycle after entering the eligible condition.
- In SERVICE for id 1, pulse irq[0]: no request until after reti. A second irq[1] edge coinciding with the ack clear leaves pending[1] = 1.
- Assert reset while in REQ: int_req drops immediately (asynchronous), pending = 0, mask = 0. gie = 0 with pending eligible: no request until gie = 1.
